// File: rtl/mul_operand_sequencer.sv
// rtl/mul_operand_sequencer.sv - operand collect / product return sequencer for an external multiplier
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   abort             synchronous clear of the current transaction (highest priority)
//   in_valid/in_ready operand handshake; data_in carries A, then B
//   op_a, op_b        registered operands driven to the multiplier
//   product_in        combinational product from the multiplier, sampled at capture
//   out_valid/out_ready result handshake; out_data carries low half, then high half
//   out_last          marks the high-half beat
//   busy              high in every state except LOAD_A
module mul_operand_sequencer #(
    parameter int WIDTH       = 8,
    parameter int MUL_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     data_in,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    input  logic [2*WIDTH-1:0]   product_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic                 busy
);

    // Latency is bounded to 1..15, so four bits always hold MUL_LATENCY-1.
    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LATENCY - 1);

    typedef enum logic [2:0] {
        S_LOAD_A = 3'd0,
        S_LOAD_B = 3'd1,
        S_WAIT   = 3'd2,
        S_OUT_LO = 3'd3,
        S_OUT_HI = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   res;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_LOAD_A;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides any handshake in the same cycle.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_LOAD_A;
        end else begin
            case (state)
                S_LOAD_A: if (in_valid)        state_nxt = S_LOAD_B;
                S_LOAD_B: if (in_valid)        state_nxt = S_WAIT;
                S_WAIT:   if (cnt == CNT_LAST) state_nxt = S_OUT_LO;
                S_OUT_LO: if (out_ready)       state_nxt = S_OUT_HI;
                S_OUT_HI: if (out_ready)       state_nxt = S_LOAD_A;
                default:                       state_nxt = S_LOAD_A;
            endcase
        end
    end

    // Datapath registers. op_a/op_b survive abort so the multiplier inputs
    // stay stable; only the in-flight result and latency counter are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a <= '0;
            op_b <= '0;
            res  <= '0;
            cnt  <= '0;
        end else if (abort) begin
            res <= '0;
            cnt <= '0;
        end else begin
            case (state)
                S_LOAD_A: begin
                    if (in_valid) op_a <= data_in;
                end
                S_LOAD_B: begin
                    if (in_valid) begin
                        op_b <= data_in;
                        cnt  <= '0;
                    end
                end
                S_WAIT: begin
                    // Counter holds at its last value on the capture edge so it never wraps.
                    if (cnt == CNT_LAST) begin
                        res <= product_in;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded purely from registered state and result.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        busy      = 1'b1;
        case (state)
            S_LOAD_A: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_LOAD_B: begin
                in_ready = 1'b1;
            end
            S_OUT_LO: begin
                out_valid = 1'b1;
                out_data  = res[WIDTH-1:0];
            end
            S_OUT_HI: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = res[2*WIDTH-1:WIDTH];
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// tb/tb_mul_operand_sequencer.sv - self-checking bench for mul_operand_sequencer
module tb_mul_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Latency-1 instance
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  data_in = '0;
    logic [7:0]  op_a, op_b;
    logic [15:0] product_in;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    // Latency-3 instance
    logic        abort3 = 1'b0;
    logic        in_valid3 = 1'b0;
    logic        in_ready3;
    logic [7:0]  data_in3 = '0;
    logic [7:0]  op_a3, op_b3;
    logic [15:0] product3 = '0;
    logic        out_valid3;
    logic        out_ready3 = 1'b0;
    logic [7:0]  out_data3;
    logic        out_last3;
    logic        busy3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Combinational multiplier model for the latency-1 instance.
    assign product_in = 16'(op_a) * 16'(op_b);

    mul_operand_sequencer #(.WIDTH(8), .MUL_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .op_a(op_a), .op_b(op_b), .product_in(product_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    mul_operand_sequencer #(.WIDTH(8), .MUL_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .abort(abort3),
        .in_valid(in_valid3), .in_ready(in_ready3), .data_in(data_in3),
        .op_a(op_a3), .op_b(op_b3), .product_in(product3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_data(out_data3), .out_last(out_last3), .busy(busy3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain product split into two beats.
    function automatic logic [15:0] model_beats(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'(a) * int'(b);
        model_beats = {8'(p / 256), 8'(p % 256)};
    endfunction

    task automatic wait_load_a();
        int n = 0;
        while (!(in_ready && !busy) && n < 20) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, in_ready && !busy}, 32'd1);
    endtask

    // Loads A then B with in_valid held high; returns in WAIT.
    task automatic load_pair(input logic [7:0] a, input logic [7:0] b, input string tag);
        in_valid = 1'b1;
        data_in  = a;
        tick();
        check({tag, "_op_a"}, {24'd0, op_a}, {24'd0, a});
        check({tag, "_ready_b"}, {31'd0, in_ready}, 32'd1);
        data_in = b;
        tick();
        in_valid = 1'b0;
        check({tag, "_op_b"}, {24'd0, op_b}, {24'd0, b});
        check({tag, "_wait_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_wait_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_wait_busy"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int stall,
                           input logic [7:0] exp_lo, input logic [7:0] exp_hi, input string tag);
        wait_load_a();
        load_pair(a, b, tag);
        tick();
        check({tag, "_valid_rise"}, {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < stall; i++) begin
            check({tag, "_stall_data"}, {24'd0, out_data}, {24'd0, exp_lo});
            check({tag, "_stall_last"}, {31'd0, out_last}, 32'd0);
            check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        check({tag, "_lo"}, {23'd0, out_valid, out_last, out_data}, {23'd0, 1'b1, 1'b0, exp_lo});
        tick();
        check({tag, "_hi"}, {23'd0, out_valid, out_last, out_data}, {23'd0, 1'b1, 1'b1, exp_hi});
        tick();
        out_ready = 1'b0;
        check({tag, "_done"}, {29'd0, out_valid, busy, in_ready}, {29'd0, 1'b0, 1'b0, 1'b1});
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         stall;
        logic [7:0] lo;
        logic [7:0] hi;
    } vec_t;

    vec_t tbl [4];

    initial begin
        logic [7:0] ra, rb;
        logic [15:0] mb;

        tbl[0] = '{a: 8'd13,  b: 8'd11,  stall: 0, lo: 8'h8F, hi: 8'h00};
        tbl[1] = '{a: 8'hFF,  b: 8'hFF,  stall: 0, lo: 8'h01, hi: 8'hFE};
        tbl[2] = '{a: 8'h00,  b: 8'h7F,  stall: 1, lo: 8'h00, hi: 8'h00};
        tbl[3] = '{a: 8'h10,  b: 8'h10,  stall: 5, lo: 8'h00, hi: 8'h01};

        // Reset state while rst is held
        #3;
        check("rst_outputs", {26'd0, in_ready, out_valid, out_last, busy, 2'b00},
              {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
        check("rst_data", {8'd0, out_data, op_a, op_b}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            run_txn(tbl[i].a, tbl[i].b, tbl[i].stall, tbl[i].lo, tbl[i].hi, $sformatf("vec%0d", i));
        end

        // Randomized transactions against the arithmetic model
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            mb = model_beats(ra, rb);
            run_txn(ra, rb, int'($urandom_range(0, 3)), mb[7:0], mb[15:8], $sformatf("rnd%0d", i));
        end

        // Abort during WAIT
        wait_load_a();
        load_pair(8'h21, 8'h43, "abw");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abw_state", {29'd0, busy, in_ready, out_valid}, {29'd0, 1'b0, 1'b1, 1'b0});
        check("abw_ops", {16'd0, op_a, op_b}, {16'd0, 8'h21, 8'h43});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abw_no_beat", {31'd0, out_valid}, 32'd0);
        end

        // Abort during OUT_HI with out_ready high
        load_pair(8'h05, 8'h06, "abh");
        tick();
        out_ready = 1'b1;
        tick();
        check("abh_in_hi", {30'd0, out_valid, out_last}, {30'd0, 1'b1, 1'b1});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        check("abh_state", {29'd0, busy, in_ready, out_valid}, {29'd0, 1'b0, 1'b1, 1'b0});
        check("abh_ops", {16'd0, op_a, op_b}, {16'd0, 8'h05, 8'h06});
        tick();
        check("abh_no_beat", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of OUT_LO
        load_pair(8'h09, 8'h09, "ar");
        tick();
        check("ar_in_lo", {31'd0, out_valid}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("ar_valid", {31'd0, out_valid}, 32'd0);
        check("ar_outs", {28'd0, in_ready, out_last, busy, 1'b0}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        check("ar_data", {8'd0, out_data, op_a, op_b}, 32'd0);
        rst = 1'b0;
        tick();
        check("ar_after", {31'd0, out_valid}, 32'd0);
        run_txn(8'd3, 8'd5, 0, 8'h0F, 8'h00, "ar_next");

        // Latency-3 instance: capture exactly three edges after B accept
        in_valid3 = 1'b1;
        data_in3  = 8'd6;
        tick();
        data_in3 = 8'd7;
        tick();
        in_valid3 = 1'b0;
        product3  = 16'hDEAD;
        check("l3_k0", {31'd0, out_valid3}, 32'd0);
        tick();
        check("l3_k1", {31'd0, out_valid3}, 32'd0);
        tick();
        check("l3_k2", {31'd0, out_valid3}, 32'd0);
        product3 = 16'(int'(op_a3) * int'(op_b3));
        tick();
        product3 = 16'hBEEF;
        check("l3_k3_valid", {31'd0, out_valid3}, 32'd1);
        check("l3_lo", {23'd0, out_last3, out_data3}, {23'd0, 1'b0, 8'h2A});
        out_ready3 = 1'b1;
        tick();
        check("l3_hi", {23'd0, out_last3, out_data3}, {23'd0, 1'b1, 8'h00});
        tick();
        out_ready3 = 1'b0;
        check("l3_done", {30'd0, out_valid3, busy3}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
